spi_sub_param: RTL and testbench

SPI_SUB_PARAM -- requirements
Module: spi_sub_param

---
 rtl/spi_sub_param.sv | 162 ++++++++++++++++
 tb/tb_spi_sub_param.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sub_param.sv
// SPI subordinate: a 2-bit header selects one of three payload lengths, and a
// snapshot of tx is shifted out on sdo. All SPI pins are synchronised into clk.
module spi_sub_param #(
    parameter int TX_W        = 128,
    parameter int PAY_MIN     = 128,
    parameter int PAY_STEP    = 64,
    parameter int CPOL        = 0,
    parameter int CPHA        = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cs,
    input  logic                            sclk,
    input  logic                            sdi,
    input  logic [TX_W-1:0]                 tx,
    output logic [2+PAY_MIN+2*PAY_STEP-1:0] rx,
    output logic                            sdo,
    output logic                            done,
    output logic                            err,
    output logic                            busy
);
    localparam int   PAY_MAX   = PAY_MIN + 2 * PAY_STEP;
    localparam int   CNT_W     = $clog2(PAY_MAX + 3);
    localparam logic SCLK_IDLE = (CPOL != 0);

    typedef enum logic [1:0] {IDLE, HDR, PAY, DRAIN} state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, sdi_sync;
    logic [SYNC_STAGES:0]   warm;
    logic                   cs_q, sclk_q;
    logic                   cs_s, sclk_s, sdi_s;
    logic                   cs_fall, cs_rise, lead, trail, sample, launch;
    logic [1:0]             hdr, hdr_code;
    logic [PAY_MAX-2:0]     sh;
    logic [CNT_W-1:0]       bit_cnt, last_bit;
    logic [TX_W:0]          tx_sh;
    logic                   start, rx_shift, hdr_load, finish;
    logic                   done_next, err_next;

    // NOTE: sequential state always uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= '1;
            sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
            sdi_sync  <= '0;
            cs_q      <= 1'b1;
            sclk_q    <= SCLK_IDLE;
            warm      <= '0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            cs_q      <= cs_s;
            sclk_q    <= sclk_s;
            warm      <= {warm[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign sdi_s  = sdi_sync[SYNC_STAGES-1];

    // A cs held low through reset flushes in as a falling edge; warm masks it
    // so a frame interrupted by reset is ignored until cs falls again.
    assign cs_fall = cs_q & ~cs_s & warm[SYNC_STAGES];
    assign cs_rise = ~cs_q & cs_s;
    assign lead    = SCLK_IDLE ? (sclk_q & ~sclk_s) : (~sclk_q & sclk_s);
    assign trail   = SCLK_IDLE ? (~sclk_q & sclk_s) : (sclk_q & ~sclk_s);
    assign sample  = (CPHA != 0) ? trail : lead;
    assign launch  = (CPHA != 0) ? lead : trail;

    assign hdr_code = {sh[0], sdi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        rx_shift   = 1'b0;
        hdr_load   = 1'b0;
        finish     = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        if (cs_rise) begin
            state_next = IDLE;
            err_next   = (state == HDR) || (state == PAY);
        end else if (cs_fall) begin
            state_next = HDR;
            start      = 1'b1;
        end else if (sample) begin
            case (state)
                HDR: begin
                    rx_shift = 1'b1;
                    if (bit_cnt == CNT_W'(1)) begin
                        if (hdr_code == 2'b11) begin
                            err_next   = 1'b1;
                            state_next = DRAIN;
                        end else begin
                            hdr_load   = 1'b1;
                            state_next = PAY;
                        end
                    end
                end
                PAY: begin
                    rx_shift = 1'b1;
                    if (bit_cnt == last_bit) begin
                        finish     = 1'b1;
                        done_next  = 1'b1;
                        state_next = DRAIN;
                    end
                end
                default: ;
            endcase
        end
    end

    // The payload register is cleared after the header so short payloads
    // arrive right-aligned and zero-extended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh       <= '0;
            bit_cnt  <= '0;
            last_bit <= '0;
            hdr      <= 2'b00;
            rx       <= '0;
            tx_sh    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= done_next;
            err  <= err_next;
            if (start) begin
                sh      <= '0;
                bit_cnt <= '0;
                tx_sh   <= (CPHA != 0) ? {1'b0, tx} : {tx, 1'b0};
            end else begin
                if (rx_shift) begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    sh      <= hdr_load ? '0 : {sh[PAY_MAX-3:0], sdi_s};
                end
                if (hdr_load) begin
                    hdr      <= hdr_code;
                    last_bit <= CNT_W'(1 + PAY_MIN + int'(hdr_code) * PAY_STEP);
                end
                if (finish)
                    rx <= {hdr, sh, sdi_s};
                if (launch && state != IDLE)
                    tx_sh <= {tx_sh[TX_W-1:0], 1'b0};
            end
        end
    end

    assign sdo  = (state != IDLE) ? tx_sh[TX_W] : 1'b0;
    assign busy = (state == HDR) || (state == PAY);

endmodule

// File: tb/tb_spi_sub_param.sv
// Bench for spi_sub_param: a bit-banged SPI master drives two instances
// (default mode and CPOL=1/CPHA=0) while a scoreboard checks done/err events.
module tb_spi_sub_param;
    typedef struct {
        logic         is_err;
        logic [257:0] rx;
    } exp_t;

    logic         clk, rst_n;
    logic         sel, cs_m, sclk_m, sdi_m;
    logic         m_cpol, m_cpha;
    int           m_half;
    logic [127:0] tx;
    logic         cs_a, sclk_a, sdo_a, done_a, err_a, busy_a;
    logic         cs_b, sclk_b, sdo_b, done_b, err_b, busy_b;
    logic [257:0] rx_a, rx_b, rx_m;
    logic         sdo_m, done_m, err_m;
    logic [257:0] model_rx_a, model_rx_b;
    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;

    assign cs_a   = sel ? 1'b1 : cs_m;
    assign sclk_a = sel ? 1'b0 : sclk_m;
    assign cs_b   = sel ? cs_m : 1'b1;
    assign sclk_b = sel ? sclk_m : 1'b1;
    assign sdo_m  = sel ? sdo_b : sdo_a;
    assign done_m = sel ? done_b : done_a;
    assign err_m  = sel ? err_b : err_a;
    assign rx_m   = sel ? rx_b : rx_a;

    spi_sub_param dut_a (
        .clk(clk), .rst_n(rst_n), .cs(cs_a), .sclk(sclk_a), .sdi(sdi_m), .tx(tx),
        .rx(rx_a), .sdo(sdo_a), .done(done_a), .err(err_a), .busy(busy_a)
    );

    spi_sub_param #(.CPOL(1), .CPHA(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .cs(cs_b), .sclk(sclk_b), .sdi(sdi_m), .tx(tx),
        .rx(rx_b), .sdo(sdo_b), .done(done_b), .err(err_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (sel ? (done_a || err_a) : (done_b || err_b)) begin
                checks++;
                errors++;
                $display("FAIL idle_instance_event: got a done/err pulse on the unselected instance, required none");
            end
            if (done_m || err_m) begin
                checks++;
                if (done_m && err_m) begin
                    errors++;
                    $display("FAIL done_err_exclusive: got done=1 err=1, required only one");
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got done=%b err=%b, required no pulse", done_m, err_m);
                end else begin
                    e = sb.pop_front();
                    if (err_m !== e.is_err || rx_m !== e.rx) begin
                        errors++;
                        $display("FAIL scoreboard_event: got err=%b rx=%h, required err=%b rx=%h",
                                 err_m, rx_m, e.is_err, e.rx);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic logic [257:0] rand258();
        logic [257:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) r = {r[225:0], 32'($urandom())};
        return r;
    endfunction

    task automatic spi_xfer(input int nbits, input logic [257:0] data, input logic raise_cs,
                            output logic [257:0] got);
        got  = '0;
        cs_m = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!m_cpha) begin
                sdi_m = data[i];
                #(m_half) sclk_m = ~m_cpol;
                #(m_half) got = {got[256:0], sdo_m};
                sclk_m = m_cpol;
            end else begin
                sclk_m = ~m_cpol;
                sdi_m  = data[i];
                #(m_half) sclk_m = m_cpol;
                #(m_half) got = {got[256:0], sdo_m};
            end
        end
        #(m_half);
        sdi_m = 1'b0;
        if (raise_cs) cs_m = 1'b1;
    endtask

    task automatic wait_sb();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({rx_a, sdo_a, done_a, err_a, busy_a} !== '0) begin
            errors++;
            $display("FAIL reset_a: got rx=%h sdo=%b done=%b err=%b busy=%b, required all 0",
                     rx_a, sdo_a, done_a, err_a, busy_a);
        end
        checks++;
        if ({rx_b, sdo_b, done_b, err_b, busy_b} !== '0) begin
            errors++;
            $display("FAIL reset_b: got rx=%h sdo=%b done=%b err=%b busy=%b, required all 0",
                     rx_b, sdo_b, done_b, err_b, busy_b);
        end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || sdo_a !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got busy=%b sdo=%b, required 0 0", busy_a, sdo_a);
        end
    endtask

    task automatic test_basic();
        logic [257:0] data, got, expv;
        logic [127:0] tx_snap;
        tx_snap = {16{8'hA5}};
        tx      = tx_snap;
        data    = '0;
        data[127:0] = {2{64'h0123_4567_89AB_CDEF}};
        expv       = data;
        model_rx_a = expv;
        sb.push_back('{is_err: 1'b0, rx: expv});
        fork
            spi_xfer(130, data, 1'b1, got);
            begin #3000; tx = ~tx_snap; end
        join
        wait_sb();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL basic_done: got %0d pending events, required 0", sb.size());
        end
        checks++;
        if (rx_a !== expv) begin
            errors++;
            $display("FAIL basic_rx_hold: got %h required %h", rx_a, expv);
        end
        checks++;
        if (got[129:2] !== tx_snap || got[1:0] !== 2'b00) begin
            errors++;
            $display("FAIL basic_sdo: got %h required %h followed by 00", got[129:0], tx_snap);
        end
    endtask

    task automatic test_lengths();
        logic [257:0] data, got, expv, r;
        logic [127:0] tx_snap;
        tx_snap = {$urandom(), $urandom(), $urandom(), $urandom()};
        tx      = tx_snap;
        data    = rand258();
        data[257:256] = 2'b10;
        expv       = data;
        model_rx_a = expv;
        sb.push_back('{is_err: 1'b0, rx: expv});
        spi_xfer(258, data, 1'b1, got);
        wait_sb();
        checks++;
        if (sb.size() != 0 || rx_a !== expv) begin
            errors++;
            $display("FAIL len_max_rx: got %h required %h", rx_a, expv);
        end
        checks++;
        if (got[257:130] !== tx_snap || got[129:0] !== '0) begin
            errors++;
            $display("FAIL len_max_sdo: got %h required %h then zeros", got, tx_snap);
        end
        r    = rand258();
        data = '0;
        data[191:0]   = r[191:0];
        data[193:192] = 2'b01;
        expv = '0;
        expv[191:0]   = r[191:0];
        expv[257:256] = 2'b01;
        model_rx_a    = expv;
        sb.push_back('{is_err: 1'b0, rx: expv});
        spi_xfer(194, data, 1'b1, got);
        wait_sb();
        checks++;
        if (sb.size() != 0 || rx_a !== expv) begin
            errors++;
            $display("FAIL len_mid_rx: got %h required %h", rx_a, expv);
        end
    endtask

    task automatic test_bad_header();
        logic [257:0] data, got, r;
        logic [127:0] tx_snap;
        tx_snap = {$urandom(), $urandom(), $urandom(), $urandom()};
        tx      = tx_snap;
        r       = rand258();
        data    = '0;
        data[39:0]  = r[39:0];
        data[41:40] = 2'b11;
        sb.push_back('{is_err: 1'b1, rx: model_rx_a});
        spi_xfer(42, data, 1'b1, got);
        wait_sb();
        checks++;
        if (sb.size() != 0 || rx_a !== model_rx_a) begin
            errors++;
            $display("FAIL bad_hdr_rx: got %h required %h", rx_a, model_rx_a);
        end
        checks++;
        if (got[41:0] !== tx_snap[127:86]) begin
            errors++;
            $display("FAIL bad_hdr_sdo: got %h required %h", got[41:0], tx_snap[127:86]);
        end
    endtask

    task automatic test_abort();
        logic [257:0] data, got, expv, r;
        tx   = '1;
        r    = rand258();
        data = '0;
        data[127:0] = r[127:0];
        spi_xfer(70, data >> 60, 1'b0, got);
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_high: got %b required 1", busy_a);
        end
        sb.push_back('{is_err: 1'b1, rx: model_rx_a});
        cs_m = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || sdo_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b sdo=%b, required 0 0", busy_a, sdo_a);
        end
        wait_sb();
        checks++;
        if (sb.size() != 0 || rx_a !== model_rx_a) begin
            errors++;
            $display("FAIL abort_rx: got %h required %h", rx_a, model_rx_a);
        end
        r    = rand258();
        data = '0;
        data[127:0] = r[127:0];
        expv        = data;
        model_rx_a  = expv;
        sb.push_back('{is_err: 1'b0, rx: expv});
        spi_xfer(130, data, 1'b1, got);
        wait_sb();
        checks++;
        if (sb.size() != 0 || rx_a !== expv) begin
            errors++;
            $display("FAIL abort_next_rx: got %h required %h", rx_a, expv);
        end
    endtask

    task automatic test_mode_b();
        logic [257:0] data, got, expv, r;
        logic [127:0] tx_snap;
        sclk_m = 1'b1;
        m_cpol = 1'b1;
        m_cpha = 1'b0;
        m_half = 20;
        sel    = 1'b1;
        repeat (8) @(negedge clk);
        tx_snap = {16{8'hA5}};
        tx      = tx_snap;
        data    = '0;
        data[127:0] = {2{64'h0123_4567_89AB_CDEF}};
        expv       = data;
        model_rx_b = expv;
        sb.push_back('{is_err: 1'b0, rx: expv});
        spi_xfer(130, data, 1'b1, got);
        wait_sb();
        checks++;
        if (sb.size() != 0 || rx_b !== expv) begin
            errors++;
            $display("FAIL modeb_rx: got %h required %h", rx_b, expv);
        end
        checks++;
        if (got[129:2] !== tx_snap || got[1:0] !== 2'b00) begin
            errors++;
            $display("FAIL modeb_sdo: got %h required %h followed by 00", got[129:0], tx_snap);
        end
        r    = rand258();
        data = '0;
        data[127:0] = r[127:0];
        fork
            spi_xfer(130, data, 1'b1, got);
            begin
                #2080;
                @(negedge clk);
                checks++;
                if (busy_b !== 1'b1) begin
                    errors++;
                    $display("FAIL modeb_busy_mid: got %b required 1", busy_b);
                end
                #1 rst_n = 1'b0;
                #1;
                checks++;
                if ({rx_b, sdo_b, done_b, err_b, busy_b} !== '0) begin
                    errors++;
                    $display("FAIL modeb_async_reset: got rx=%h sdo=%b done=%b err=%b busy=%b, required all 0",
                             rx_b, sdo_b, done_b, err_b, busy_b);
                end
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        model_rx_a = '0;
        model_rx_b = '0;
        wait_sb();
        checks++;
        if (rx_b !== '0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL modeb_after_reset: got rx=%h busy=%b, required 0 0", rx_b, busy_b);
        end
        r    = rand258();
        data = '0;
        data[191:0]   = r[191:0];
        data[193:192] = 2'b01;
        expv = '0;
        expv[191:0]   = r[191:0];
        expv[257:256] = 2'b01;
        model_rx_b    = expv;
        sb.push_back('{is_err: 1'b0, rx: expv});
        spi_xfer(194, data, 1'b1, got);
        wait_sb();
        checks++;
        if (sb.size() != 0 || rx_b !== expv) begin
            errors++;
            $display("FAIL modeb_recover_rx: got %h required %h", rx_b, expv);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        sel        = 1'b0;
        cs_m       = 1'b1;
        sclk_m     = 1'b0;
        sdi_m      = 1'b0;
        m_cpol     = 1'b0;
        m_cpha     = 1'b1;
        m_half     = 40;
        tx         = '0;
        model_rx_a = '0;
        model_rx_b = '0;
        test_reset();
        test_basic();
        test_lengths();
        test_bad_header();
        test_abort();
        test_mode_b();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
